// File: rtl/pri_enc_8x3_q.sv
// ============================================================================
// Module      : pri_enc_8x3_q
// Description : Queued 8-to-3 priority encoder. Captures request lines into a
//               pending set and delivers each one as an index on a valid/ready
//               handshake, clearing the bit on acceptance.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pri_enc_8x3_q #(
  parameter int HIGH_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [2:0] y,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pend,
  output logic       none
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_n;
  logic [7:0] r_pend;
  logic [7:0] w_pend_n;
  logic [7:0] w_cap;
  logic [7:0] w_clr;
  logic [2:0] r_y;
  logic [2:0] w_y_n;
  logic [2:0] w_enc;
  logic       w_acc;

  // Set wins over clear: a bit re-requested on its accept edge stays pending.
  always_comb begin
    w_cap    = en ? 8'h00 : req;
    w_acc    = (r_state == S_OFFER) && ready;
    w_clr    = w_acc ? (8'h01 << r_y) : 8'h00;
    w_pend_n = (r_pend & ~w_clr) | w_cap;
  end

  // Later loop iterations override earlier ones, so scan order sets priority.
  always_comb begin
    w_enc = 3'd0;
    if (HIGH_FIRST != 0) begin
      for (int i = 0; i < 8; i++) begin
        if (w_pend_n[i]) w_enc = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (w_pend_n[i]) w_enc = 3'(i);
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_y_n     = r_y;
    case (r_state)
      S_IDLE: begin
        if (w_pend_n != 8'h00) begin
          w_y_n     = w_enc;
          w_state_n = S_OFFER;
        end
      end
      S_OFFER: begin
        if (w_acc) begin
          if (w_pend_n != 8'h00) begin
            w_y_n = w_enc;
          end else begin
            w_state_n = S_IDLE;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pend  <= 8'h00;
      r_y     <= 3'd0;
    end else begin
      r_state <= w_state_n;
      r_pend  <= w_pend_n;
      r_y     <= w_y_n;
    end
  end

  assign y     = r_y;
  assign valid = (r_state == S_OFFER);
  assign pend  = r_pend;
  assign none  = (r_pend == 8'h00);

endmodule

`default_nettype wire

// File: doc/pri_enc_8x3_q.md
Name: pri_enc_8x3_q

Overview:
- Queued 8-to-3 priority encoder: the encode-side counterpart of the 3x8 decoder.
- Captures one-hot or multi-hot request lines into a pending register.
- Presents one 3-bit index at a time on a valid/ready handshake.
- Clears each bit as its index is accepted.
- Sits in front of dec_3x8-style consumers so that every captured request is delivered exactly once as an index.

Parameters:
- HIGH_FIRST, 1: 1 = highest pending index wins; 0 = lowest pending index wins.

Ports:
- clk     input   1  rising-edge clock
- rst     input   1  synchronous reset, active-high
- en      input   1  active-low capture enable; 0 = req sampled, 1 = req ignored
- req     input   8  request lines, sampled every clock while en=0; bit i requests index i
- y       output  3  encoded index of the presented request (registered)
- valid   output  1  y holds a presented request (registered)
- ready   input   1  consumer accepts y when valid=1 and ready=1 on the same edge
- pend    output  8  pending request bits, excluding none (registered; includes the bit currently presented)
- none    output  1  combinational: pend==0

Behaviour:
- Reset (rst=1 at a clock edge) sets pend=0, y=3'b000, valid=0 and state IDLE.
  - rst overrides every other input and aborts an unaccepted offer.
  - None of the suppressed requests or offers reappear after reset.
- Definitions:
  - cap = req when en=0, else 8'h00.
  - acc = valid & ready.
  - clr = one-hot(y) when acc=1, else 8'h00.
  - pend_n = (pend & ~clr) | cap. Set wins over clear: a req on the bit being accepted in the same cycle leaves that bit pending.
- pend <= pend_n every clock edge.
- enc(v):
  - HIGH_FIRST=1: index of the most-significant 1 in v.
  - HIGH_FIRST=0: index of the least-significant 1 in v.
  - enc is undefined for v=0 and is never loaded in that case.
- State IDLE (valid=0):
  - pend_n != 0 -> y <= enc(pend_n), valid <= 1, go to OFFER.
  - Otherwise stay in IDLE and hold y.
  - Latency: req sampled at edge k gives valid=1 and y set right after edge k. The request is visible in the cycle following its sample edge.
- State OFFER (valid=1):
  - acc=0: y and valid hold. New higher-priority requests merge into pend but do not preempt the current y. y must never change while valid=1 and ready=0.
  - acc=1 and pend_n != 0: y <= enc(pend_n), stay in OFFER. This is back-to-back delivery at one index per clock.
  - acc=1 and pend_n == 0: valid <= 0, go to IDLE, y holds its last value.
- Duplicate requests:
  - A req on a bit already pending merges and is delivered once. There is no counting.
  - A bit re-requested after its acceptance is delivered again.
- en=1 blocks capture only. Pending bits and any offer in progress continue to drain normally.
- ready while valid=0 has no effect.
- Multi-hot req in a single cycle: all bits are captured and delivered in priority order on consecutive accepts.

Test Plan:
- Reset, then idle: rst=1 for 2 cycles with req=8'hFF, en=0 -> pend=0, valid=0, y=0, none=1. The cycle after rst drops, with req=0: valid stays 0.
- Single request: en=0, req=8'h20 for one cycle, ready=1 -> next cycle valid=1, y=5, pend=8'h20. The cycle after, valid=0, pend=0, none=1.
- Multi-hot drain: HIGH_FIRST=1, req=8'hA5 for one cycle, ready held 1 -> y sequence 7,5,2,0 on consecutive cycles, then valid=0. Repeat with HIGH_FIRST=0 -> 0,2,5,7.
- Backpressure and no preemption:
  - req=8'h01, ready=0 -> y=0, valid=1.
  - Then req=8'h80 -> y stays 0 for 5 cycles with ready=0, pend=8'h81.
  - Raise ready -> y=0 accepted, then y=7, then idle.
- Enable gating: en=1 with req=8'hFF for 3 cycles -> pend=0, valid=0. While 8'h06 is pending and en is switched to 1, indices 2 and 1 still drain.
- Set-wins-over-clear and mid-operation reset:
  - y=3 offered; assert ready=1 and req=8'h08 on the same edge -> pend keeps bit 3 and y=3 is offered again next cycle.
  - Then rst=1 during the offer -> valid=0, pend=0 on the following cycle.
